// File: rtl/regdst_pipe.sv
// regdst_pipe: selects an instruction's destination register, carries it
// with its write enable through DEPTH stages (stall/flush aware), presents
// the write-back destination, and flags the youngest in-flight producer of
// two decode-stage source registers.
module regdst_pipe #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               rt_in,
  input  logic [WIDTH-1:0]               rd_in,
  input  logic [1:0]                     sel,
  input  logic                           reg_write,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               src_a,
  input  logic [WIDTH-1:0]               src_b,
  output logic [WIDTH-1:0]               dest_out,
  output logic                           we_out,
  output logic [DEPTH-1:0]               match_a,
  output logic [DEPTH-1:0]               match_b,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_b
);

  localparam int unsigned FW = $clog2(DEPTH + 1);

  // Stage 0 is youngest, stage DEPTH-1 is write-back.
  logic [WIDTH-1:0] dest_q [DEPTH];
  logic [WIDTH-1:0] dest_d [DEPTH];
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] we_d;

  logic [WIDTH-1:0] entry_dest;
  logic             entry_we;

  // Destination selection; writes to $0 are never tracked.
  always_comb begin
    entry_dest = '0;
    case (sel)
      2'd0:    entry_dest = rt_in;
      2'd1:    entry_dest = rd_in;
      2'd2:    entry_dest = WIDTH'(LINK_REG);
      default: entry_dest = '0;
    endcase
    entry_we = in_valid & reg_write & (sel != 2'd3) & (entry_dest != '0);
  end

  // Next-state for every stage: stall holds stage 0 and bubbles stage 1,
  // flush kills whatever would be captured into stage 0.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      dest_d[k] = dest_q[k];
    end
    we_d = we_q;

    if (flush) begin
      dest_d[0] = '0;
      we_d[0]   = 1'b0;
    end else if (!stall) begin
      dest_d[0] = entry_dest;
      we_d[0]   = entry_we;
    end

    for (int k = 1; k < int'(DEPTH); k++) begin
      if (k == 1 && stall) begin
        dest_d[k] = '0;
        we_d[k]   = 1'b0;
      end else begin
        dest_d[k] = dest_q[k-1];
        we_d[k]   = we_q[k-1];
      end
    end
  end

  // Stage registers with synchronous reset to bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        dest_q[k] <= '0;
      end
      we_q <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        dest_q[k] <= dest_d[k];
      end
      we_q <= we_d;
    end
  end

  // Per-stage hit vectors and youngest-hit encoding; $0 never hits.
  always_comb begin
    match_a = '0;
    match_b = '0;
    fwd_a   = '0;
    fwd_b   = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      match_a[k] = we_q[k] & (dest_q[k] == src_a) & (src_a != '0);
      match_b[k] = we_q[k] & (dest_q[k] == src_b) & (src_b != '0);
    end
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (match_a[k]) fwd_a = FW'(k + 1);
      if (match_b[k]) fwd_b = FW'(k + 1);
    end
  end

  // Write-back view is the oldest stage.
  always_comb begin
    dest_out = dest_q[DEPTH-1];
    we_out   = we_q[DEPTH-1];
  end

endmodule

// File: tb/tb_regdst_pipe.sv
// Directed bench for regdst_pipe at default parameters (WIDTH=5, DEPTH=3).
module tb_regdst_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] rt_in;
  logic [4:0] rd_in;
  logic [1:0] sel;
  logic       reg_write;
  logic       stall;
  logic       flush;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic [4:0] dest_out;
  logic       we_out;
  logic [2:0] match_a;
  logic [2:0] match_b;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  int n_cmp = 0;
  int n_err = 0;

  regdst_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .rt_in    (rt_in),
    .rd_in    (rd_in),
    .sel      (sel),
    .reg_write(reg_write),
    .stall    (stall),
    .flush    (flush),
    .src_a    (src_a),
    .src_b    (src_b),
    .dest_out (dest_out),
    .we_out   (we_out),
    .match_a  (match_a),
    .match_b  (match_b),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; rt_in = '0; rd_in = '0; sel = 2'd0; reg_write = 1'b0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic cap_rt(input logic [4:0] r);
    in_valid = 1'b1; reg_write = 1'b1; sel = 2'd0; rt_in = r;
  endtask

  initial begin
    idle();
    rst = 1'b1; src_a = '0; src_b = '0;

    // Reset
    step(); step();
    chk("rst_dest", dest_out, 0);
    chk("rst_we", we_out, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    rst = 1'b0;
    step(); step();
    chk("idle_we", we_out, 0);
    chk("idle_match_a", match_a, 0);

    // Select modes: rt, rd, link, none
    in_valid = 1'b1; reg_write = 1'b1; rt_in = 5'd5; rd_in = 5'd9;
    sel = 2'd0; step();
    sel = 2'd1; step();
    sel = 2'd2; step();
    chk("sel_rt_dest", dest_out, 5);
    chk("sel_rt_we", we_out, 1);
    src_a = 5'd9; #1;
    chk("sel_mid_match_a", match_a, 3'b010);
    chk("sel_mid_fwd_a", fwd_a, 2);
    src_a = '0;
    sel = 2'd3; step();
    chk("sel_rd_dest", dest_out, 9);
    chk("sel_rd_we", we_out, 1);
    idle(); step();
    chk("sel_link_dest", dest_out, 31);
    chk("sel_link_we", we_out, 1);
    step();
    chk("sel_none_dest", dest_out, 0);
    chk("sel_none_we", we_out, 0);
    step(); step();

    // $0 suppression and reg_write=0
    in_valid = 1'b1; reg_write = 1'b1; sel = 2'd1; rd_in = 5'd0; src_a = '0;
    step(); chk("zero_match0", match_a, 0);
    step(); chk("zero_match1", match_a, 0);
    step(); chk("zero_match2", match_a, 0);
    chk("zero_we", we_out, 0);
    sel = 2'd0; rt_in = 5'd12; reg_write = 1'b0; src_a = 5'd12;
    step(); #1;
    chk("nowrite_match", match_a, 0);
    idle(); src_a = '0;
    step(); step(); step();

    // Forwarding priority: 7, 7, 3
    cap_rt(5'd7); step();
    cap_rt(5'd7); step();
    cap_rt(5'd3); step();
    idle(); src_a = 5'd7; src_b = 5'd3; #1;
    chk("fwd_match_a", match_a, 3'b110);
    chk("fwd_fwd_a", fwd_a, 2);
    chk("fwd_match_b", match_b, 3'b001);
    chk("fwd_fwd_b", fwd_b, 1);
    chk("fwd_dest", dest_out, 7);
    src_a = '0; src_b = '0;
    step(); step(); step();

    // Stall: 4 held in stage 0 for two cycles
    cap_rt(5'd4); step();
    stall = 1'b1; src_a = 5'd4;
    step();
    chk("stall1_match", match_a, 3'b001);
    chk("stall1_fwd", fwd_a, 1);
    chk("stall1_we", we_out, 0);
    step();
    chk("stall2_match", match_a, 3'b001);
    chk("stall2_we", we_out, 0);
    idle();
    step();
    chk("unstall1_match", match_a, 3'b010);
    chk("unstall1_we", we_out, 0);
    step();
    chk("unstall2_dest", dest_out, 4);
    chk("unstall2_we", we_out, 1);
    chk("unstall2_match", match_a, 3'b100);
    src_a = '0;
    step(); step(); step();

    // Flush kills capture of 6
    cap_rt(5'd6); flush = 1'b1; step();
    idle(); src_a = 5'd6; #1;
    chk("flush_match", match_a, 0);
    step(); chk("flush_we1", we_out, 0);
    step(); chk("flush_we2", we_out, 0);

    // Flush without stall still advances old stage 0
    cap_rt(5'd11); step();
    cap_rt(5'd12); flush = 1'b1; step();
    idle(); src_a = 5'd11; src_b = 5'd12; #1;
    chk("flush_adv_match_a", match_a, 3'b010);
    chk("flush_adv_match_b", match_b, 0);
    step(); step(); step();

    // Flush with stall bubbles both stage 0 and stage 1
    cap_rt(5'd10); step();
    cap_rt(5'd13); step();
    stall = 1'b1; flush = 1'b1; step();
    idle(); src_a = 5'd10; src_b = 5'd13; #1;
    chk("flush_stall_match_a", match_a, 3'b100);
    chk("flush_stall_match_b", match_b, 0);
    src_a = '0; src_b = '0;
    step(); step(); step();

    // Reset mid-stream loses 8
    cap_rt(5'd8); step();
    idle(); src_a = 5'd8; #1;
    chk("pre_rst_match", match_a, 3'b001);
    rst = 1'b1; step();
    chk("post_rst_match", match_a, 0);
    chk("post_rst_fwd", fwd_a, 0);
    chk("post_rst_we", we_out, 0);
    rst = 1'b0;
    step(); chk("post_rst_we1", we_out, 0);
    step(); chk("post_rst_we2", we_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regdst_pipe.md
# regdst_pipe

Parametrised destination-register selector and write-back tracker for the pipelined MIPS core. Each cycle it picks an instruction's destination register (rt, rd, link register or none), carries destination and write-enable through DEPTH pipeline stages with stall and flush, and presents the write-back destination at the last stage. Every cycle it also compares two decode-stage source registers against all in-flight destinations and reports the youngest match, for use by forwarding and hazard logic.

## Interface
Parameters:
- WIDTH, 5, register-index width.
- DEPTH, 3, number of tracked stages (≥1); stage 0 is youngest, stage DEPTH-1 is write-back.
- LINK_REG, 31, destination used for link (jal) instructions.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  an instruction is presented for capture.
- rt_in  in  WIDTH  rt field of the incoming instruction.
- rd_in  in  WIDTH  rd field of the incoming instruction.
- sel  in  2  destination select: 0 = rt, 1 = rd, 2 = LINK_REG, 3 = no destination.
- reg_write  in  1  incoming instruction writes the register file.
- stall  in  1  hold stage 0, insert a bubble into stage 1.
- flush  in  1  kill the instruction being captured into stage 0.
- src_a, src_b  in  WIDTH  decode-stage source register indices to check.
- dest_out  out  WIDTH  destination at stage DEPTH-1.
- we_out  out  1  register-file write enable at stage DEPTH-1.
- match_a, match_b  out  DEPTH  per-stage hit vector; bit k = stage k hits.
- fwd_a, fwd_b  out  $clog2(DEPTH+1)  0 = no hit, k+1 = youngest hitting stage is k.

## Operation
- Per-stage state: dest[WIDTH], we[1].
- Entry computation: d = rt_in / rd_in / LINK_REG / 0 for sel 0/1/2/3. e = in_valid & reg_write & (sel != 3) & (d != 0). Writes to $0 are never tracked.
- Normal advance (stall=0, flush=0): stage 0 ← {d, e}; stage k ← stage k-1 for k ≥ 1.
- stall=1, flush=0: stage 0 holds; stage 1 ← bubble (we=0, dest=0); stages k ≥ 2 ← stage k-1. Inputs are ignored. With DEPTH=1 only stage 0 holds.
- flush=1: stage 0 ← bubble regardless of stall or inputs. Stage 1 ← bubble if stall=1, else ← old stage 0. Stages k ≥ 2 advance.
- Bubble: we=0, dest=0.
- rst=1: all stages ← bubble. Reset overrides stall, flush and in_valid.
- match_a[k] = we[k] & (dest[k] == src_a) & (src_a != 0); match_b is the same with src_b.
- fwd_a = k+1 for the lowest k with match_a[k] set (youngest wins), else 0. fwd_b is the same with match_b.
- dest_out = dest[DEPTH-1]; we_out = we[DEPTH-1].

## Timing
- Reset values: dest_out=0, we_out=0, match_*=0, fwd_*=0.
- Latency: an instruction captured at edge N appears on dest_out/we_out after edge N+DEPTH-1, counting only edges with stall=0.
- Each stall cycle adds one cycle of latency for the stalled instruction. Instructions already in stages ≥1 are not delayed.
- match_* and fwd_* are purely combinational from stage registers and src_*. They are valid in the same cycle; there is no src-to-register path.
- No ready/valid back-pressure. The caller must keep rt_in/rd_in/sel stable while stall=1 and re-present them on the cycle stall drops.
- Back-to-back instructions with the same dest: both tracked; fwd_* reports the younger.
- rst asserted mid-stream: all in-flight writes are lost after that edge; we_out=0 on the following cycle.

## Test plan
- Reset, DEPTH=3: hold rst 2 cycles, then rst=0 with idle inputs → dest_out=0, we_out=0, fwd_a=fwd_b=0 throughout.
- Select modes: rt_in=5, rd_in=9, reg_write=1, with sel=0,1,2,3 on consecutive cycles → dest_out sequence 5, 9, 31, 0 starting 2 cycles after the first capture; we_out 1, 1, 1, 0.
- $0 suppression: sel=1, rd_in=0, reg_write=1 → we_out=0; with src_a=0, match_a=000 in every cycle.
- Forwarding priority: capture dest 7 (sel=0, rt_in=7), then dest 7 again, then dest 3. With src_a=7, src_b=3 after the third edge → match_a=110, fwd_a=2, match_b=001, fwd_b=1.
- Stall: capture dest 4, then stall=1 for 2 cycles → stage 0 holds 4, stage 1 shows bubbles; dest_out=4 with we_out=1 appears 2 cycles after stall deasserts.
- Flush and reset mid-stream: capture dest 6 with flush=1 → never appears on we_out. Capture dest 8, then assert rst one cycle later → we_out stays 0 and match vectors clear the cycle after reset.
